// File: rtl/adventure_game_fsm.sv
// Room-walking adventure FSM: cave -> tunnel -> river -> (sword stash) -> dragon -> vault/graveyard.
// Optional ADV_AUTO_RESTART_EN: terminal rooms return to the cave after 16 enabled edges.
module adventure_game_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] direction,
   output logic [2:0] room,
   output logic       sword,
   output logic       result
);

   typedef enum logic [2:0] {
      ROOM_CAVE    = 3'b000,
      ROOM_TUNNEL  = 3'b001,
      ROOM_RIVER   = 3'b010,
      ROOM_STASH   = 3'b011,
      ROOM_DRAGON  = 3'b100,
      ROOM_VAULT   = 3'b101,
      ROOM_GRAVE   = 3'b110,
      ROOM_ILLEGAL = 3'b111
   } room_e;

   localparam logic [1:0] DIR_NORTH = 2'b00;
   localparam logic [1:0] DIR_EAST  = 2'b01;
   localparam logic [1:0] DIR_SOUTH = 2'b10;
   localparam logic [1:0] DIR_WEST  = 2'b11;

   room_e room_q, room_d;
   logic  sword_q, sword_d;
   logic  result_q, result_d;

`ifdef ADV_AUTO_RESTART_EN
   localparam int unsigned CNT_W = 4;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   // Next-state: illegal code recovers regardless of start; otherwise move only when enabled.
   always_comb begin
      room_d  = room_q;
      sword_d = sword_q;
`ifdef ADV_AUTO_RESTART_EN
      cnt_d   = cnt_q;
`endif
      if (room_q == ROOM_ILLEGAL) begin
         room_d  = ROOM_CAVE;
         sword_d = 1'b0;
      end else if (start) begin
         case (room_q)
            ROOM_CAVE:   if (direction == DIR_EAST) room_d = ROOM_TUNNEL;
            ROOM_TUNNEL: if (direction == DIR_WEST) room_d = ROOM_RIVER;
            ROOM_RIVER: begin
               if (direction == DIR_SOUTH) begin
                  room_d  = ROOM_STASH;
                  sword_d = 1'b1;
               end else if (direction == DIR_EAST) begin
                  room_d = ROOM_DRAGON;
               end
            end
            ROOM_STASH:  if (direction == DIR_NORTH) room_d = ROOM_RIVER;
            ROOM_DRAGON: begin
               room_d = sword_q ? ROOM_VAULT : ROOM_GRAVE;
`ifdef ADV_AUTO_RESTART_EN
               cnt_d  = '0;
`endif
            end
            ROOM_VAULT, ROOM_GRAVE: begin
`ifdef ADV_AUTO_RESTART_EN
               if (cnt_q == {CNT_W{1'b1}}) begin
                  room_d  = ROOM_CAVE;
                  sword_d = 1'b0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
`else
               room_d = room_q;
`endif
            end
            default: room_d = ROOM_CAVE;
         endcase
      end
      result_d = (room_d == ROOM_VAULT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         room_q   <= ROOM_CAVE;
         sword_q  <= 1'b0;
         result_q <= 1'b0;
`ifdef ADV_AUTO_RESTART_EN
         cnt_q    <= '0;
`endif
      end else begin
         room_q   <= room_d;
         sword_q  <= sword_d;
         result_q <= result_d;
`ifdef ADV_AUTO_RESTART_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign room   = room_q;
   assign sword  = sword_q;
   assign result = result_q;

endmodule

// File: tb/tb_adventure_game_fsm.sv
// Directed self-checking bench for adventure_game_fsm (win, loss, start gate, reset, restart option).
module tb_adventure_game_fsm;

   logic       clk;
   logic       reset;
   logic       start;
   logic [1:0] direction;
   logic [2:0] room;
   logic       sword;
   logic       result;

   int unsigned n_cmp;
   int unsigned n_mis;

   adventure_game_fsm dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .direction (direction),
      .room      (room),
      .sword     (sword),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [2:0] r, input logic s, input logic res);
      check_eq({tag, "_room"},   8'(room),   8'(r));
      check_eq({tag, "_sword"},  8'(sword),  8'(s));
      check_eq({tag, "_result"}, 8'(result), 8'(res));
   endtask

   initial begin
      n_cmp     = 0;
      n_mis     = 0;
      reset     = 1'b1;
      start     = 1'b0;
      direction = 2'b00;
      step(2);
      check_all("reset", 3'b000, 1'b0, 1'b0);
      reset = 1'b0;

      // start gate
      direction = 2'b01;
      step(7);
      check_eq("gate_hold", 8'(room), 8'd0);
      start = 1'b1;
      step(1);
      check_eq("gate_go", 8'(room), 8'd1);

      // held direction in tunnel has no effect
      step(10);
      check_eq("tunnel_hold", 8'(room), 8'd1);

      // win path
      direction = 2'b11;
      step(7);
      check_all("river", 3'b010, 1'b0, 1'b0);
      direction = 2'b10;
      step(1);
      check_all("stash", 3'b011, 1'b1, 1'b0);
      step(6);
      check_eq("stash_hold", 8'(room), 8'd3);
      direction = 2'b00;
      step(7);
      check_all("river_sword", 3'b010, 1'b1, 1'b0);
      direction = 2'b01;
      step(1);
      check_all("dragon_win", 3'b100, 1'b1, 1'b0);
      step(1);
      check_all("vault", 3'b101, 1'b1, 1'b1);
      step(5);
      check_all("vault_hold", 3'b101, 1'b1, 1'b1);

      // start=0 freezes everything
      start = 1'b0;
      direction = 2'b10;
      step(4);
      check_all("vault_frozen", 3'b101, 1'b1, 1'b1);

      // reset in terminal room
      start = 1'b1;
      reset = 1'b1;
      step(3);
      check_all("vault_reset", 3'b000, 1'b0, 1'b0);
      reset = 1'b0;

      // loss path
      direction = 2'b01;
      step(1);
      check_eq("loss_tunnel", 8'(room), 8'd1);
      direction = 2'b11;
      step(1);
      check_eq("loss_river", 8'(room), 8'd2);
      direction = 2'b00;
      step(2);
      check_eq("river_north_stay", 8'(room), 8'd2);
      direction = 2'b01;
      step(1);
      check_all("dragon_lose", 3'b100, 1'b0, 1'b0);
      step(1);
      check_all("grave", 3'b110, 1'b0, 1'b0);

      // restart option: disabled edges do not count toward the 16
      start = 1'b0;
      step(20);
      check_eq("grave_frozen", 8'(room), 8'd6);
      start = 1'b1;
      step(15);
      check_all("grave_15", 3'b110, 1'b0, 1'b0);
      step(1);
`ifdef ADV_AUTO_RESTART_EN
      check_all("grave_16", 3'b000, 1'b0, 1'b0);
`else
      check_all("grave_16", 3'b110, 1'b0, 1'b0);
`endif

      // reset mid-game then restart from cave without sword
      direction = 2'b01;
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      check_all("restart_rst", 3'b000, 1'b0, 1'b0);
      step(1);
      check_all("restart_go", 3'b001, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/adventure_game_fsm.md
ADVENTURE_GAME_FSM -- requirements
Module: Adventure_Game

Interface
REQ-001 SHALL have port clk, input, 1 bit; single clock, all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit; game enable, level-sensitive.
REQ-004 SHALL have port direction, input, 2 bits; 00=North, 01=East, 10=South, 11=West.
REQ-005 SHALL have port room, output, 3 bits; current room code, registered.
REQ-006 SHALL have port sword, output, 1 bit; 1 once the sword is held, registered.
REQ-007 SHALL have port result, output, 1 bit; 1 only in Victory Vault, registered.
REQ-008 SHALL have no parameters; the room encoding is fixed as listed in REQ-009.

Function
REQ-009 SHALL encode rooms as: 000 Cave of Cacophony, 001 Twisty Tunnel, 010 Rapid River, 011 Secret Sword Stash, 100 Dragon Den, 101 Victory Vault, 110 Grievous Graveyard; 111 is illegal.
REQ-010 SHALL evaluate at most one transition per rising clk edge, and only when start=1 and reset=0; with start=0, room, sword and result hold their values.
REQ-011 SHALL transition from Cave to Tunnel on direction 01; all other directions stay in Cave.
REQ-012 SHALL transition from Tunnel to River on direction 11; all other directions stay.
REQ-013 SHALL transition from River to Sword Stash on direction 10 and to Dragon Den on direction 01; 00 and 11 stay.
REQ-014 SHALL transition from Sword Stash to River on direction 00; all other directions stay.
REQ-015 SHALL leave Dragon Den on the next enabled edge regardless of direction: to Vault if sword=1, else to Graveyard.
REQ-016 SHALL treat Vault and Graveyard as terminal, staying there until reset (see REQ-024 for the exception).
REQ-017 SHALL make direction level-sensitive, so a held direction never moves more than once unless the new room also defines that direction; sword=1 SHALL be set on the same edge that room becomes 011.
REQ-018 SHALL keep sword=1 sticky until reset, including after leaving the Stash and in terminal rooms.
REQ-019 SHALL drive result=1 exactly while room=101 and 0 in every other room, including Graveyard.
REQ-020 SHALL recover from illegal room 111 to Cave with sword=0 on the next edge, even with start=0.

Reset
REQ-021 SHALL, on a rising edge with reset=1, set room=000, sword=0, result=0, overriding start and direction.
REQ-022 SHALL, after reset mid-game (for example in Graveyard), restart the game from Cave without the sword once reset=0 and start=1.

Configuration
REQ-023 SHALL support the macro ADV_AUTO_RESTART_EN.
REQ-024 SHALL, with ADV_AUTO_RESTART_EN defined, return from Vault or Graveyard to Cave with sword=0 and result=0 after 16 consecutive enabled edges in the terminal room, using an internal 4-bit counter cleared on entry to the terminal room and on reset.
REQ-025 SHALL, without ADV_AUTO_RESTART_EN, make terminal rooms hold indefinitely until reset, with no counter logic present.

Verification
REQ-026 SHALL verify win path: start=1, then each direction held 7 cycles in the order 01, 11, 10, 00, 01 -> room 000->001->010->011 (sword=1)->010->100->101, with result=1.
REQ-027 SHALL verify loss path: after reset, start=1, then 01, 11, 01 -> room 000->001->010->100->110, with sword=0 and result=0.
REQ-028 SHALL verify the start gate: direction=01 held for 7 cycles with start=0 -> room stays 000; start=1 -> room=001 one edge later.
REQ-029 SHALL verify that holding direction has no effect: in Tunnel, direction 01 held for 10 cycles -> room stays 001.
REQ-030 SHALL verify reset in a terminal room: reset=1 for 3 cycles while in Vault -> room=000, sword=0, result=0.
REQ-031 SHALL verify the restart option: with ADV_AUTO_RESTART_EN defined, in Graveyard with start=1 for 16 edges -> room=000; without the macro, room stays 110.
